maskable_carry_adder_pipe: RTL
==============================

# maskable_carry_adder_pipe

Parametrised, pipelined adder built from per-bit maskable cells: each bit position is either an exact full adder or the approximate cell (sum = a|b|cin, carry-out = 0), selected by a runtime mask. The ripple chain is cut into SEG-bit segments with a register between segments, giving one result per cycle under a valid/ready handshake. It sits in the approximate multiplier datapath as the partial-product accumulation adder. It replaces the fixed four-bit maskable carry adder.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of SEG.
- SEG, 4, bits per pipeline segment; latency L = WIDTH/SEG.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  load cfg_mask into the mask register.
- cfg_mask  in  WIDTH  per-bit mode; 1 = approximate cell, 0 = exact full adder.
- in_valid  in  1  operands valid.
- in_ready  out  1  adder can accept operands.
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result sum.
- out_cout  out  1  carry out of bit WIDTH-1.
- err_flag  out  1  result differs from the exact sum; qualified by out_valid.
- err_count  out  CNT_W  saturating count of erroneous results delivered.
- err_clr  in  1  synchronous clear of err_count.

## Operation
- Cell rule for bit i, with carry c and m = mask[i]:
  - m=1: s = a|b|c, carry-out = 0.
  - m=0: s = a^b^c, carry-out = majority(a,b,c).
- Bit 0 carry-in is in_cin.
- The mask register resets to 0 (all bits exact) and loads on cfg_we.
- The mask is sampled when a transaction is accepted (in_valid && in_ready) and travels with that transaction. Later mask loads never affect transactions already in flight.
- If cfg_we and an accept occur in the same cycle, the accepted transaction uses the old mask value.
- Segment k (bits k·SEG .. k·SEG+SEG-1) is evaluated in stage k.
  - The inter-segment carry is registered.
  - Operand bits and mask bits for later segments are skewed through delay registers.
  - Completed sum bits are delayed so that all WIDTH bits appear together at the output.
- Stall: a single global enable, adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=0, every pipeline register holds its value. No data is lost or duplicated, and order is preserved.
- Bubbles (valid=0 entries) propagate like data; only valid entries reach out_valid.
- Reset, including mid-operation: all in-flight entries are discarded.
  - out_valid=0, out_sum=0, out_cout=0, mask=0, err_flag=0, err_count=0.
  - in_ready=1 in the first cycle after rst deasserts.

## Timing
- Latency: an accept in cycle t gives out_valid=1 in cycle t+L when there is no stall. For WIDTH=16 and SEG=4, L=4.
- Throughput: one result per cycle while out_ready=1.
- out_sum, out_cout and err_flag are registered, and stay stable while out_valid=1 and out_ready=0.
- err_count updates one cycle after a delivered result (out_valid && out_ready && err_flag).
  - It saturates at 2^CNT_W-1.
  - If err_clr coincides with an increment, err_clr wins and the counter becomes 0.

## Configuration
- MCA_ERR_STATS_EN defined:
  - An exact reference sum a+b+cin (WIDTH+1 bits) is carried through the pipeline.
  - err_flag = ({out_cout, out_sum} != exact).
  - err_count is active as described above.
- MCA_ERR_STATS_EN undefined:
  - No reference datapath or counter is built.
  - err_flag and err_count are driven constant 0, and err_clr is ignored.
  - The ports remain present.

## Test plan
Parameters for all scenarios: WIDTH=16, SEG=4.
- Exact mode: mask=0x0000, a=0x00FF, b=0x0001, cin=0 -> out_sum=0x0100, out_cout=0, err_flag=0, exactly 4 cycles after the accept.
- Low-nibble approximate: mask=0x000F, a=0x000F, b=0x0001 -> out_sum=0x000F, out_cout=0, err_flag=1 (exact result 0x0010); err_count=1 after delivery.
- Fully approximate: mask=0xFFFF, a=0xFFFF, b=0x0001, cin=1 -> out_sum=0xFFFF, out_cout=0, err_flag=1.
- Backpressure:
  - Stimulus: 6 back-to-back accepts with a=i, b=i, mask=0, and out_ready=0 for cycles 5–7.
  - Required: results 0,2,4,6,8,10 delivered in order with none lost; in_ready=0 while out_valid=1 and out_ready=0.
- Mask race:
  - Stimulus: cfg_we with mask=0xFFFF in the same cycle as accepting a=0x0001, b=0x0001 under old mask 0.
  - Required: that result is 0x0002. The next accept of the same operands gives 0x0001.
- Reset mid-flight: assert rst with 3 transactions in flight -> out_valid=0 immediately, no stale result after release, and err_count=0.

Source files
------------

// File: rtl/maskable_carry_adder_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maskable_carry_adder_pipe_if                                             |
// | Operand/result handshake bundle for the pipelined maskable carry adder.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface maskable_carry_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             err_flag;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, err_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, err_flag
  );
endinterface
`default_nettype wire

// File: rtl/maskable_carry_adder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maskable_carry_adder_pipe                                                |
// | Segmented, pipelined ripple adder with per-bit exact/approximate cells.  |
// | Optional error statistics: define MCA_ERR_STATS_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module maskable_carry_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  cfg_we,
  input  wire logic [WIDTH-1:0]      cfg_mask,
  maskable_carry_adder_pipe_if.slave bus,
  output logic [CNT_W-1:0]           err_count,
  input  wire logic                  err_clr
);

  localparam int c_L = WIDTH / SEG;

  logic             w_adv;
  logic             w_out_valid;
  logic [WIDTH-1:0] r_mask;

  // One SEG-bit slice of the cell chain; returns {carry_out, sum}.
  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic [SEG-1:0] m,
    input logic           ci
  );
    logic [SEG-1:0] s;
    logic           c;
    c = ci;
    s = '0;
    for (int i = 0; i < SEG; i++) begin
      if (m[i]) begin
        s[i] = a[i] | b[i] | c;
        c    = 1'b0;
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
    end
    return {c, s};
  endfunction

  assign w_adv        = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (cfg_we) begin
      r_mask <= cfg_mask;
    end
  end

  genvar k;
  generate
    for (k = 0; k < c_L; k++) begin : g_stage
      localparam int c_UP = WIDTH - (k + 1) * SEG;

      logic [SEG-1:0]         w_a;
      logic [SEG-1:0]         w_b;
      logic [SEG-1:0]         w_m;
      logic                   w_ci;
      logic                   w_vi;
      logic [SEG:0]           w_res;
      logic [(k+1)*SEG-1:0]   w_sum_nxt;
      logic                   r_valid;
      logic                   r_carry;
      logic [(k+1)*SEG-1:0]   r_sum;

      if (k == 0) begin : g_head
        assign w_a       = bus.in_a[SEG-1:0];
        assign w_b       = bus.in_b[SEG-1:0];
        assign w_m       = r_mask[SEG-1:0];
        assign w_ci      = bus.in_cin;
        assign w_vi      = bus.in_valid;
        assign w_sum_nxt = w_res[SEG-1:0];
      end else begin : g_body
        assign w_a       = g_stage[k-1].g_skew.r_a[SEG-1:0];
        assign w_b       = g_stage[k-1].g_skew.r_b[SEG-1:0];
        assign w_m       = g_stage[k-1].g_skew.r_m[SEG-1:0];
        assign w_ci      = g_stage[k-1].r_carry;
        assign w_vi      = g_stage[k-1].r_valid;
        assign w_sum_nxt = {w_res[SEG-1:0], g_stage[k-1].r_sum};
      end

      assign w_res = seg_add(w_a, w_b, w_m, w_ci);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_sum   <= '0;
        end else if (w_adv) begin
          r_valid <= w_vi;
          r_carry <= w_res[SEG];
          r_sum   <= w_sum_nxt;
        end
      end

      // Operand and mask bits of segments not yet evaluated ride along here.
      if (c_UP > 0) begin : g_skew
        logic [c_UP-1:0] w_a_up;
        logic [c_UP-1:0] w_b_up;
        logic [c_UP-1:0] w_m_up;
        logic [c_UP-1:0] r_a;
        logic [c_UP-1:0] r_b;
        logic [c_UP-1:0] r_m;

        if (k == 0) begin : g_src_in
          assign w_a_up = bus.in_a[WIDTH-1:SEG];
          assign w_b_up = bus.in_b[WIDTH-1:SEG];
          assign w_m_up = r_mask[WIDTH-1:SEG];
        end else begin : g_src_prev
          assign w_a_up = g_stage[k-1].g_skew.r_a[WIDTH-k*SEG-1:SEG];
          assign w_b_up = g_stage[k-1].g_skew.r_b[WIDTH-k*SEG-1:SEG];
          assign w_m_up = g_stage[k-1].g_skew.r_m[WIDTH-k*SEG-1:SEG];
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_m <= '0;
          end else if (w_adv) begin
            r_a <= w_a_up;
            r_b <= w_b_up;
            r_m <= w_m_up;
          end
        end
      end

`ifdef MCA_ERR_STATS_EN
      logic [WIDTH:0] w_ref_in;

      if (k == 0) begin : g_ref_src_in
        assign w_ref_in = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.in_cin};
      end else begin : g_ref_src_prev
        assign w_ref_in = g_stage[k-1].g_ref.r_ref;
      end

      if (k < c_L - 1) begin : g_ref
        logic [WIDTH:0] r_ref;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_ref <= '0;
          end else if (w_adv) begin
            r_ref <= w_ref_in;
          end
        end
      end else begin : g_err
        // Compared as the last segment completes so the flag is a register.
        logic r_err;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_err <= 1'b0;
          end else if (w_adv) begin
            r_err <= ({w_res[SEG], w_sum_nxt} != w_ref_in);
          end
        end
      end
`endif
    end
  endgenerate

  assign w_out_valid   = g_stage[c_L-1].r_valid;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = g_stage[c_L-1].r_sum;
  assign bus.out_cout  = g_stage[c_L-1].r_carry;

`ifdef MCA_ERR_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_err_flag;
  logic [CNT_W-1:0] r_err_count;

  assign w_err_flag = g_stage[c_L-1].g_err.r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_out_valid && bus.out_ready && w_err_flag && (r_err_count != c_CNT_MAX)) begin
      r_err_count <= r_err_count + c_CNT_ONE;
    end
  end

  assign bus.err_flag = w_err_flag;
  assign err_count    = r_err_count;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign bus.err_flag     = 1'b0;
  assign err_count        = '0;
`endif

endmodule
`default_nettype wire
